// File: rtl/f32_op_scheduler_if.sv
// Requester and adder-side signals of the float32 operation scheduler.
// The scheduler uses the slave modport; requesters plus the adder use the master modport.
interface f32_op_scheduler_if #(
  parameter int N     = 2,
  parameter int CNT_W = 16
);
  logic [N-1:0]      REQ;
  logic [32*N-1:0]   REQ_A;
  logic [32*N-1:0]   REQ_B;
  logic [N-1:0]      REQ_OP;
  logic [N-1:0]      DONE;
  logic [2:0]        GNT_ID;
  logic [31:0]       RES;
  logic              RES_OVF;
  logic              RES_UNF;
  logic              BUSY;
  logic [31:0]       ADD_A;
  logic [31:0]       ADD_B;
  logic              ADD_OP;
  logic [31:0]       ADD_R;
  logic              ADD_OVF;
  logic              ADD_UNF;
  logic              STICKY_OVF;
  logic              STICKY_UNF;
  logic [CNT_W-1:0]  OP_COUNT;

  modport slave (
    input  REQ, REQ_A, REQ_B, REQ_OP, ADD_R, ADD_OVF, ADD_UNF,
    output DONE, GNT_ID, RES, RES_OVF, RES_UNF, BUSY,
           ADD_A, ADD_B, ADD_OP, STICKY_OVF, STICKY_UNF, OP_COUNT
  );

  modport master (
    output REQ, REQ_A, REQ_B, REQ_OP, ADD_R, ADD_OVF, ADD_UNF,
    input  DONE, GNT_ID, RES, RES_OVF, RES_UNF, BUSY,
           ADD_A, ADD_B, ADD_OP, STICKY_OVF, STICKY_UNF, OP_COUNT
  );
endinterface

// File: rtl/f32_op_scheduler.sv
// Round-robin sharing of one combinational float32 adder-subtractor between N requesters,
// with settle-time sequencing, result/flag capture, sticky flags and a saturating op counter.
module f32_op_scheduler #(
  parameter int N      = 2,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  f32_op_scheduler_if.slave bus
);
  localparam int         SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [3:0] NL = 4'(N);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_gnt;
  logic [2:0]       r_ptr;
  logic [SW-1:0]    r_cnt;
  logic [31:0]      r_res;
  logic             r_res_ovf;
  logic             r_res_unf;
  logic [31:0]      r_add_a;
  logic [31:0]      r_add_b;
  logic             r_add_op;
  logic             r_sticky_ovf;
  logic             r_sticky_unf;
  logic [CNT_W-1:0] r_op_count;

  logic [N-1:0]     w_rot;
  logic             w_found;
  logic [2:0]       w_off;
  logic [3:0]       w_sum;
  logic [2:0]       w_win;
  logic [31:0]      w_win_a;
  logic [31:0]      w_win_b;
  logic             w_win_op;
  logic             w_capture;
  logic [N-1:0]     w_done;

  // Rotate requests so bit 0 is the pointer position; the first set bit is the winner's offset.
  always_comb begin : arb
    w_rot   = N'({bus.REQ, bus.REQ} >> r_ptr);
    w_found = 1'b0;
    w_off   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = 3'(k);
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    w_win = (w_sum >= NL) ? 3'(w_sum - NL) : w_sum[2:0];
  end

  always_comb begin : opsel
    w_win_a  = '0;
    w_win_b  = '0;
    w_win_op = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (3'(k) == w_win) begin
        w_win_a  = bus.REQ_A[32*k +: 32];
        w_win_b  = bus.REQ_B[32*k +: 32];
        w_win_op = bus.REQ_OP[k];
      end
    end
  end

  always_comb begin : fsm
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_done      = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == SW'(1)) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        for (int unsigned k = 0; k < N; k++) begin
          w_done[k] = (3'(k) == r_gnt);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_gnt        <= '0;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_res        <= '0;
      r_res_ovf    <= 1'b0;
      r_res_unf    <= 1'b0;
      r_add_a      <= '0;
      r_add_b      <= '0;
      r_add_op     <= 1'b0;
      r_sticky_ovf <= 1'b0;
      r_sticky_unf <= 1'b0;
      r_op_count   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_found) begin
        r_add_a  <= w_win_a;
        r_add_b  <= w_win_b;
        r_add_op <= w_win_op;
        r_gnt    <= w_win;
        r_cnt    <= SW'(SETTLE);
      end
      if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - SW'(1);
      end
      if (w_capture) begin
        r_res        <= bus.ADD_R;
        r_res_ovf    <= bus.ADD_OVF;
        r_res_unf    <= bus.ADD_UNF;
        r_sticky_ovf <= r_sticky_ovf | bus.ADD_OVF;
        r_sticky_unf <= r_sticky_unf | bus.ADD_UNF;
        if (r_op_count != '1) r_op_count <= r_op_count + CNT_W'(1);
      end
      if (r_state == S_DONE) begin
        r_ptr <= (r_gnt == 3'(N - 1)) ? '0 : r_gnt + 3'd1;
      end
    end
  end

  assign bus.DONE       = w_done;
  assign bus.GNT_ID     = r_gnt;
  assign bus.RES        = r_res;
  assign bus.RES_OVF    = r_res_ovf;
  assign bus.RES_UNF    = r_res_unf;
  assign bus.BUSY       = (r_state != S_IDLE);
  assign bus.ADD_A      = r_add_a;
  assign bus.ADD_B      = r_add_b;
  assign bus.ADD_OP     = r_add_op;
  assign bus.STICKY_OVF = r_sticky_ovf;
  assign bus.STICKY_UNF = r_sticky_unf;
  assign bus.OP_COUNT   = r_op_count;
endmodule

// File: tb/tb_f32_op_scheduler.sv
// Directed bench for f32_op_scheduler: two instances share stimulus, the second with a
// 2-bit operation counter to exercise saturation. The adder is a lookup of the vectors used.
module tb_f32_op_scheduler;
  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [63:0] a;
  logic [63:0] b;
  logic [1:0]  op;
  int          n_assert;
  int          n_fail;

  f32_op_scheduler_if #(.N(2), .CNT_W(16)) bus0 ();
  f32_op_scheduler_if #(.N(2), .CNT_W(2))  bus1 ();

  f32_op_scheduler #(.N(2), .SETTLE(2), .CNT_W(16)) u_dut0 (
    .CLK(clk), .RESET(rst), .bus(bus0.slave)
  );
  f32_op_scheduler #(.N(2), .SETTLE(2), .CNT_W(2)) u_dut1 (
    .CLK(clk), .RESET(rst), .bus(bus1.slave)
  );

  // {ovf, unf, result} for the operand pairs the stimulus uses
  function automatic logic [33:0] fadd(input logic [31:0] x, input logic [31:0] y, input logic s);
    if (!s && x == 32'h3F800000 && y == 32'h40000000) return {2'b00, 32'h40400000};
    if ( s && x == 32'h40400000 && y == 32'h3F800000) return {2'b00, 32'h40000000};
    if (!s && x == 32'h7F7FFFFF && y == 32'h7F7FFFFF) return {2'b10, 32'h7F800000};
    if ( s && x == 32'h00800001 && y == 32'h00800000) return {2'b01, 32'h00000001};
    if (!s && x == 32'h40000000 && y == 32'h40400000) return {2'b00, 32'h40A00000};
    if (x == 32'h0 && y == 32'h0) return {2'b00, 32'h0};
    return {2'b00, 32'h7FC00000};
  endfunction

  assign bus0.REQ = req;  assign bus0.REQ_A = a;  assign bus0.REQ_B = b;  assign bus0.REQ_OP = op;
  assign bus1.REQ = req;  assign bus1.REQ_A = a;  assign bus1.REQ_B = b;  assign bus1.REQ_OP = op;
  assign {bus0.ADD_OVF, bus0.ADD_UNF, bus0.ADD_R} = fadd(bus0.ADD_A, bus0.ADD_B, bus0.ADD_OP);
  assign {bus1.ADD_OVF, bus1.ADD_UNF, bus1.ADD_R} = fadd(bus1.ADD_A, bus1.ADD_B, bus1.ADD_OP);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    req = 2'b00;
    a   = '0;
    b   = '0;
    op  = 2'b00;
    step();
    step();
    rst = 1'b0;

    // reset state
    chk("rst_done",   64'(bus0.DONE), 64'h0);
    chk("rst_gnt",    64'(bus0.GNT_ID), 64'h0);
    chk("rst_busy",   64'(bus0.BUSY), 64'h0);
    chk("rst_res",    64'(bus0.RES), 64'h0);
    chk("rst_adda",   64'(bus0.ADD_A), 64'h0);
    chk("rst_cnt",    64'(bus0.OP_COUNT), 64'h0);
    chk("rst_sticky", 64'({bus0.STICKY_OVF, bus0.STICKY_UNF}), 64'h0);

    // 1: single add from requester 0
    req = 2'b01; a = {32'h0, 32'h3F800000}; b = {32'h0, 32'h40000000}; op = 2'b00;
    step();
    chk("t1_c1_busy", 64'(bus0.BUSY), 64'h1);
    chk("t1_c1_done", 64'(bus0.DONE), 64'h0);
    chk("t1_c1_adda", 64'(bus0.ADD_A), 64'h3F800000);
    step();
    chk("t1_c2_done", 64'(bus0.DONE), 64'h0);
    step();
    chk("t1_c3_done", 64'(bus0.DONE), 64'h1);
    chk("t1_res",     64'(bus0.RES), 64'h40400000);
    chk("t1_ovf",     64'(bus0.RES_OVF), 64'h0);
    chk("t1_cnt",     64'(bus0.OP_COUNT), 64'h1);
    chk("t1_gnt",     64'(bus0.GNT_ID), 64'h0);
    req = 2'b00;
    step();
    chk("t1_c4_done", 64'(bus0.DONE), 64'h0);
    chk("t1_c4_busy", 64'(bus0.BUSY), 64'h0);

    // 2: subtract from requester 1, operands changed after grant must not reach the adder
    req = 2'b10; a = {32'h40400000, 32'h11111111}; b = {32'h3F800000, 32'h22222222}; op = 2'b10;
    step();
    chk("t2_c1_gnt",  64'(bus0.GNT_ID), 64'h1);
    chk("t2_c1_add",  {bus0.ADD_A, bus0.ADD_B}, {32'h40400000, 32'h3F800000});
    chk("t2_c1_op",   64'(bus0.ADD_OP), 64'h1);
    a = '0; b = '0; op = 2'b00;
    step();
    chk("t2_c2_add",  {bus0.ADD_A, bus0.ADD_B}, {32'h40400000, 32'h3F800000});
    chk("t2_c2_op",   64'(bus0.ADD_OP), 64'h1);
    step();
    chk("t2_c3_done", 64'(bus0.DONE), 64'h2);
    chk("t2_res",     64'(bus0.RES), 64'h40000000);
    req = 2'b00;
    step();

    // 3: contention, both held; pointer is 0 so grants run 0,1,0,1
    req = 2'b11;
    a = {32'h40400000, 32'h3F800000}; b = {32'h3F800000, 32'h40000000}; op = 2'b10;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_gnt",  64'(bus0.GNT_ID), 64'(i % 2));
      step();
      chk("t3_c2_done", 64'(bus0.DONE), 64'h0);
      step();
      chk("t3_done", 64'(bus0.DONE), (i % 2 == 0) ? 64'h1 : 64'h2);
      chk("t3_res",  64'(bus0.RES), (i % 2 == 0) ? 64'h40400000 : 64'h40000000);
      if (i == 3) req = 2'b00;
      step();
    end
    chk("t3_cnt",     64'(bus0.OP_COUNT), 64'd6);
    chk("t3_cnt_sat", 64'(bus1.OP_COUNT), 64'd3);

    // 4: overflow then clean op then underflow; flags stay sticky
    req = 2'b01; a = {32'h0, 32'h7F7FFFFF}; b = {32'h0, 32'h7F7FFFFF}; op = 2'b00;
    step(); step(); step();
    chk("t4_done",    64'(bus0.DONE), 64'h1);
    chk("t4_res",     64'(bus0.RES), 64'h7F800000);
    chk("t4_ovf",     64'(bus0.RES_OVF), 64'h1);
    chk("t4_sticky",  64'({bus0.STICKY_OVF, bus0.STICKY_UNF}), 64'h2);
    req = 2'b00;
    step();
    req = 2'b10; a = {32'h3F800000, 32'h0}; b = {32'h40000000, 32'h0}; op = 2'b00;
    step(); step(); step();
    chk("t4b_res",    64'(bus0.RES), 64'h40400000);
    chk("t4b_ovf",    64'(bus0.RES_OVF), 64'h0);
    chk("t4b_sticky", 64'(bus0.STICKY_OVF), 64'h1);
    req = 2'b00;
    step();
    req = 2'b01; a = {32'h0, 32'h00800001}; b = {32'h0, 32'h00800000}; op = 2'b01;
    step(); step(); step();
    chk("t4c_res",    64'(bus0.RES), 64'h00000001);
    chk("t4c_unf",    64'({bus0.RES_OVF, bus0.RES_UNF}), 64'h1);
    chk("t4c_sticky", 64'({bus0.STICKY_OVF, bus0.STICKY_UNF}), 64'h3);
    chk("t4c_cnt",    64'(bus0.OP_COUNT), 64'd9);
    req = 2'b00;
    step();

    // 5: reset in WAIT cycle 1 aborts with no DONE and clears everything
    req = 2'b10; a = {32'h40000000, 32'h0}; b = {32'h40400000, 32'h0}; op = 2'b00;
    step();
    chk("t5_c1_gnt",  64'(bus0.GNT_ID), 64'h1);
    chk("t5_c1_busy", 64'(bus0.BUSY), 64'h1);
    rst = 1'b1;
    step();
    chk("t5_busy",    64'(bus0.BUSY), 64'h0);
    chk("t5_done",    64'(bus0.DONE), 64'h0);
    chk("t5_res",     64'(bus0.RES), 64'h0);
    chk("t5_add",     {bus0.ADD_A, bus0.ADD_B}, 64'h0);
    chk("t5_gnt",     64'(bus0.GNT_ID), 64'h0);
    chk("t5_cnt",     64'(bus0.OP_COUNT), 64'h0);
    chk("t5_sticky",  64'({bus0.STICKY_OVF, bus0.STICKY_UNF}), 64'h0);
    step();
    chk("t5_done2",   64'(bus0.DONE), 64'h0);
    // pointer back at 0: with both requesting, requester 0 wins
    rst = 1'b0; req = 2'b11;
    a = {32'h40000000, 32'h3F800000}; b = {32'h40400000, 32'h40000000}; op = 2'b00;
    step();
    chk("t5_regnt",   64'(bus0.GNT_ID), 64'h0);
    chk("t5_readda",  64'(bus0.ADD_A), 64'h3F800000);
    step(); step();
    chk("t5_redone",  64'(bus0.DONE), 64'h1);
    chk("t5_reres",   64'(bus0.RES), 64'h40400000);
    chk("t5_recnt",   64'({bus1.OP_COUNT, bus0.OP_COUNT}), {62'h0, 2'd1} << 16 | 64'd1);

    // 6: requester 0 drops REQ in cycle 1, DONE still pulses in cycle 3
    req = 2'b01;
    step();
    step();
    chk("t6_c1_gnt",  64'(bus0.GNT_ID), 64'h0);
    req = 2'b00;
    step();
    chk("t6_c2_busy", 64'(bus0.BUSY), 64'h1);
    step();
    chk("t6_done",    64'(bus0.DONE), 64'h1);
    chk("t6_cnt1",    64'(bus1.OP_COUNT), 64'd2);
    step();
    step();
    chk("t6_idle",    64'(bus0.BUSY), 64'h0);
    // held request: three more ops, 2-bit counter reaches 3 and holds
    req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step(); step(); step();
      chk("t6_hdone", 64'(bus0.DONE), 64'h1);
      chk("t6_sat",   64'(bus1.OP_COUNT), 64'd3);
      chk("t6_cnt",   64'(bus0.OP_COUNT), 64'(3 + i));
      if (i == 2) req = 2'b00;
      step();
    end
    step();
    chk("t6_final_busy", 64'(bus0.BUSY), 64'h0);
    chk("t6_final_sat",  64'(bus1.OP_COUNT), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
